// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU's SRAM-like bus. The IF/EXE stages, the
// request arbiter and the future AXI bridge use the same request struct.
// The transaction IDs tell which master owns an outstanding response.
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

    // Transaction owner IDs stored in the arbiter's in-order ID FIFO.
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // One SRAM-like request beat (71 bits).
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;   // bytes = 2**size
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    localparam int SRAM_REQ_W = $bits(sram_req_t);

    function automatic sram_req_t pack_sram_req(
        input logic        wr,
        input logic [1:0]  size,
        input logic [3:0]  wstrb,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        sram_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wstrb;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// -----------------------------------------------------------------------------
// id_fifo
// Generic synchronous FIFO. Push and pop each take effect at the clock edge.
// A push while full and a pop while empty are ignored. DEPTH must be a power
// of two, so the read and write pointers wrap through plain overflow.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push_i/push_data_i write one entry
//   pop_i              discard the head entry
//   head_o             current head entry, valid while !empty_o
//   full_o/empty_o     occupancy flags
//   count_o            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module id_fifo #(
    parameter  int WIDTH   = 1,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int COUNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   push_data_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [COUNT_W-1:0] count_o
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push_ok, pop_ok;

    assign full_o  = (count_q == COUNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;  // idle, or push and pop together
        endcase
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // update together at the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset. Reads are only
    // meaningful while count_q says the slot holds data, and leaving the
    // array out of reset lets it map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like memory port between the instruction-fetch (inst) and
// load/store (data) SRAM-like masters. Data has fixed priority. A request
// that has been offered but not yet accepted locks the grant to its master
// until it is accepted. Each accepted transaction pushes its owner ID into an
// in-order FIFO. Each mem_data_ok pops the FIFO and is returned to that owner.
// Request and response paths are combinational, so latency is zero and the
// port accepts at most one transaction per cycle.
//
// Parameters:
//   OUTSTANDING  maximum accepted-but-unanswered transactions (power of 2, 2..16)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   {inst,data}_sram_req/wr/size/wstrb/addr/wdata   master requests (in)
//   {inst,data}_sram_addr_ok/data_ok/rdata          master handshakes (out)
//   mem_req/wr/size/wstrb/addr/wdata                merged request (out)
//   mem_addr_ok/data_ok/rdata                       memory handshakes (in)
// -----------------------------------------------------------------------------
module sram_req_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(OUTSTANDING);

    logic      lock_q, lock_d;
    logic      lock_sel_q, lock_sel_d;

    logic      grant_valid;
    logic      grant_id;
    logic      grant_req;
    sram_req_t inst_req_s, data_req_s, grant_req_s;

    logic      handshake;
    logic      resp_pop;

    logic       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [PTR_W:0] fifo_count;

    assign inst_req_s = pack_sram_req(inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                                      inst_sram_addr, inst_sram_wdata);
    assign data_req_s = pack_sram_req(data_sram_wr, data_sram_size, data_sram_wstrb,
                                      data_sram_addr, data_sram_wdata);

    // Grant: a pending (locked) request keeps the port, otherwise data wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_INST;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_id    = lock_sel_q;
        end else if (data_sram_req) begin
            grant_valid = 1'b1;
            grant_id    = ID_DATA;
        end else if (inst_sram_req) begin
            grant_valid = 1'b1;
            grant_id    = ID_INST;
        end
    end

    // Request mux. The fields are zero when nobody holds the grant.
    always_comb begin
        grant_req   = 1'b0;
        grant_req_s = '0;
        if (grant_valid) begin
            if (grant_id == ID_DATA) begin
                grant_req   = data_sram_req;
                grant_req_s = data_req_s;
            end else begin
                grant_req   = inst_sram_req;
                grant_req_s = inst_req_s;
            end
        end
    end

    // Full is taken from registered occupancy only. A pop in the same cycle
    // does not reopen the port, which keeps mem_data_ok off the mem_req path.
    assign mem_req   = grant_req & ~fifo_full;
    assign mem_wr    = grant_req_s.wr;
    assign mem_size  = grant_req_s.size;
    assign mem_wstrb = grant_req_s.wstrb;
    assign mem_addr  = grant_req_s.addr;
    assign mem_wdata = grant_req_s.wdata;

    assign handshake         = mem_req & mem_addr_ok;
    assign inst_sram_addr_ok = handshake & (grant_id == ID_INST);
    assign data_sram_addr_ok = handshake & (grant_id == ID_DATA);

    // A response that arrives while nothing is outstanding is dropped.
    assign resp_pop          = mem_data_ok & ~fifo_empty;
    assign inst_sram_data_ok = resp_pop & (fifo_head == ID_INST);
    assign data_sram_data_ok = resp_pop & (fifo_head == ID_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    // Lock holds the grant on a request that was offered and not yet
    // accepted, so the address a master has presented stays on the bus.
    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (mem_req && !mem_addr_ok) begin
            lock_d     = 1'b1;
            lock_sel_d = grant_id;
        end else if (handshake) begin
            lock_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_sel_q <= ID_INST;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    id_fifo #(
        .WIDTH (1),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (handshake),
        .push_data_i (grant_id),
        .pop_i       (resp_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // The occupancy count is kept for debug visibility only. The control
    // logic above uses the full/empty flags.
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
// Directed scenarios check fixed expected constants. A randomized phase
// compares every output against a behavioural model that keeps outstanding
// owners in a queue.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam int OUTSTANDING = 4;

    logic        clk;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata)
    );

    logic [2:0] fifo_count;
    assign fifo_count = dut.u_id_fifo.count_o;

    logic [139:0] dut_vec;
    assign dut_vec = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
                      inst_sram_addr_ok, inst_sram_data_ok,
                      data_sram_addr_ok, data_sram_data_ok,
                      inst_sram_rdata, data_sram_rdata};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bit           m_q[$];     // owners of outstanding transactions, oldest first
    bit           m_lock;     // an offered request is waiting for acceptance
    bit           m_sel;      // owner of that waiting request
    bit           m_g;
    bit           m_mreq;
    logic [139:0] exp_vec;

    task automatic model_eval();
        bit          gv;
        bit          g;
        bit          greq;
        logic [70:0] f;
        bit          iok, dok, idok, ddok;
        gv = 0; g = 0; greq = 0; f = '0;
        if (m_lock)             begin gv = 1; g = m_sel; end
        else if (data_sram_req) begin gv = 1; g = 1;     end
        else if (inst_sram_req) begin gv = 1; g = 0;     end
        if (gv && g) begin
            greq = data_sram_req;
            f = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};
        end else if (gv) begin
            greq = inst_sram_req;
            f = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
        end
        m_mreq = greq && (m_q.size() < OUTSTANDING);
        m_g    = g;
        iok  = m_mreq && mem_addr_ok && !g;
        dok  = m_mreq && mem_addr_ok && g;
        idok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == 1'b0);
        ddok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == 1'b1);
        exp_vec = {m_mreq, f, iok, idok, dok, ddok, mem_rdata, mem_rdata};
    endtask

    task automatic model_clock();
        if (reset) begin
            m_q.delete();
            m_lock = 0;
            m_sel  = 0;
        end else begin
            model_eval();
            if (mem_data_ok && m_q.size() > 0) void'(m_q.pop_front());
            if (m_mreq && mem_addr_ok) begin
                m_q.push_back(m_g);
                m_lock = 0;
            end else if (m_mreq) begin
                m_lock = 1;
                m_sel  = m_g;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        idle();
        repeat (3) begin
            @(negedge clk);
            if (dut_vec !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", dut_vec); end
            n_cmp++;
            next_cycle();
        end
        reset = 0;
        @(negedge clk);
        if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok} !== 5'b0) begin
            n_err++; $display("FAIL idle_handshakes: got %b expected 00000",
                {mem_req, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok});
        end
        n_cmp++;
        if (fifo_count !== 3'd0) begin n_err++; $display("FAIL idle_count: got %0d expected 0", fifo_count); end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_priority();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
        data_sram_req = 1; data_sram_addr = 32'h0000_1000;
        mem_addr_ok = 1;
        @(negedge clk);
        if ({mem_addr, data_sram_addr_ok, inst_sram_addr_ok} !== {32'h0000_1000, 2'b10}) begin
            n_err++; $display("FAIL prio_data_first: got %h/%b%b expected 00001000/10",
                mem_addr, data_sram_addr_ok, inst_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        data_sram_req = 0;
        @(negedge clk);
        if ({mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {32'h1c00_0000, 2'b10}) begin
            n_err++; $display("FAIL prio_inst_second: got %h/%b%b expected 1c000000/10",
                mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
        mem_data_ok = 1; mem_rdata = 32'hAAAA_0000;
        @(negedge clk);
        if ({data_sram_data_ok, inst_sram_data_ok, data_sram_rdata} !== {2'b10, 32'hAAAA_0000}) begin
            n_err++; $display("FAIL prio_resp0: got %b%b/%h expected 10/aaaa0000",
                data_sram_data_ok, inst_sram_data_ok, data_sram_rdata);
        end
        n_cmp++;
        next_cycle();
        mem_rdata = 32'hBBBB_0000;
        @(negedge clk);
        if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'hBBBB_0000}) begin
            n_err++; $display("FAIL prio_resp1: got %b%b/%h expected 10/bbbb0000",
                inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        n_cmp++;
        next_cycle();
        idle();
    endtask

    task automatic test_lock();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin data_sram_req = 1; data_sram_addr = 32'h0000_2000; end
            @(negedge clk);
            if ({mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {1'b1, 32'h1c00_0100, 2'b00}) begin
                n_err++; $display("FAIL lock_hold c%0d: got %b/%h/%b%b expected 1/1c000100/00",
                    c, mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
            end
            n_cmp++;
            next_cycle();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        if ({mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {32'h1c00_0100, 2'b10}) begin
            n_err++; $display("FAIL lock_accept: got %h/%b%b expected 1c000100/10",
                mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        inst_sram_req = 0;
        @(negedge clk);
        if ({mem_addr, data_sram_addr_ok} !== {32'h0000_2000, 1'b1}) begin
            n_err++; $display("FAIL lock_release: got %h/%b expected 00002000/1", mem_addr, data_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
        mem_data_ok = 1;
        @(negedge clk);
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin
            n_err++; $display("FAIL lock_resp0: got %b%b expected 10", inst_sram_data_ok, data_sram_data_ok);
        end
        n_cmp++;
        next_cycle();
        @(negedge clk);
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin
            n_err++; $display("FAIL lock_resp1: got %b%b expected 01", inst_sram_data_ok, data_sram_data_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
    endtask

    task automatic test_full();
        inst_sram_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < OUTSTANDING; i++) begin
            inst_sram_addr = 32'h0000_0100 + 32'(4 * i);
            @(negedge clk);
            if (inst_sram_addr_ok !== 1'b1) begin
                n_err++; $display("FAIL full_fill%0d: got %b expected 1", i, inst_sram_addr_ok);
            end
            n_cmp++;
            next_cycle();
        end
        inst_sram_addr = 32'h0000_0200;
        @(negedge clk);
        if ({mem_req, inst_sram_addr_ok, fifo_count} !== {2'b00, 3'd4}) begin
            n_err++; $display("FAIL full_block: got %b%b/%0d expected 00/4", mem_req, inst_sram_addr_ok, fifo_count);
        end
        n_cmp++;
        next_cycle();
        mem_data_ok = 1;
        @(negedge clk);
        if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b001) begin
            n_err++; $display("FAIL full_pop_same_cycle: got %b%b%b expected 001",
                mem_req, inst_sram_addr_ok, inst_sram_data_ok);
        end
        n_cmp++;
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        if ({mem_req, inst_sram_addr_ok} !== 2'b11) begin
            n_err++; $display("FAIL full_reopen: got %b%b expected 11", mem_req, inst_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
        mem_data_ok = 1;
        repeat (OUTSTANDING) next_cycle();
        idle();
        @(negedge clk);
        if (fifo_count !== 3'd0) begin n_err++; $display("FAIL full_drain: got %0d expected 0", fifo_count); end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_empty_and_reset();
        mem_data_ok = 1; mem_rdata = $urandom;
        @(negedge clk);
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            n_err++; $display("FAIL spurious_resp: got %b%b expected 00", inst_sram_data_ok, data_sram_data_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
        @(negedge clk);
        if (fifo_count !== 3'd0) begin n_err++; $display("FAIL spurious_count: got %0d expected 0", fifo_count); end
        n_cmp++;
        next_cycle();
        inst_sram_req = 1; mem_addr_ok = 1;
        repeat (2) next_cycle();
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
        mem_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({inst_sram_data_ok, data_sram_data_ok, fifo_count} !== {2'b00, 3'd0}) begin
                n_err++; $display("FAIL post_reset_resp%0d: got %b%b/%0d expected 00/0",
                    i, inst_sram_data_ok, data_sram_data_ok, fifo_count);
            end
            n_cmp++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_store();
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_wstrb = 4'b1111;
        data_sram_addr = 32'h0000_3000; data_sram_wdata = 32'h1234_5678; mem_addr_ok = 1;
        @(negedge clk);
        if ({mem_wr, mem_size, mem_wstrb, mem_wdata, data_sram_addr_ok} !== {1'b1, 2'd2, 4'b1111, 32'h1234_5678, 1'b1}) begin
            n_err++; $display("FAIL store_req: got %b/%0d/%b/%h/%b expected 1/2/1111/12345678/1",
                mem_wr, mem_size, mem_wstrb, mem_wdata, data_sram_addr_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
        mem_data_ok = 1;
        @(negedge clk);
        if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10) begin
            n_err++; $display("FAIL store_resp: got %b%b expected 10", data_sram_data_ok, inst_sram_data_ok);
        end
        n_cmp++;
        next_cycle();
        idle();
    endtask

    task automatic test_random();
        idle();
        reset = 1;
        model_clock();
        next_cycle();
        reset = 0;
        for (int c = 0; c < 600; c++) begin
            reset           = ($urandom_range(0, 149) == 0);
            inst_sram_req   = $urandom_range(0, 1) == 1;
            inst_sram_wr    = $urandom_range(0, 1) == 1;
            inst_sram_size  = 2'($urandom);
            inst_sram_wstrb = 4'($urandom);
            inst_sram_addr  = $urandom;
            inst_sram_wdata = $urandom;
            data_sram_req   = $urandom_range(0, 2) == 0;
            data_sram_wr    = $urandom_range(0, 1) == 1;
            data_sram_size  = 2'($urandom);
            data_sram_wstrb = 4'($urandom);
            data_sram_addr  = $urandom;
            data_sram_wdata = $urandom;
            mem_addr_ok     = $urandom_range(0, 2) != 0;
            mem_data_ok     = $urandom_range(0, 2) == 0;
            mem_rdata       = $urandom;
            @(negedge clk);
            model_eval();
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL rand_outputs c%0d: got %h expected %h", c, dut_vec, exp_vec);
            end
            n_cmp++;
            if (int'(fifo_count) != m_q.size()) begin
                n_err++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, fifo_count, m_q.size());
            end
            n_cmp++;
            model_clock();
            next_cycle();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_empty_and_reset();
        test_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
